// File: rtl/i2c_pkg.sv
// Shared I2C definitions: bus-phase state encodings (common to master and slave
// control paths), field widths and the SCL quarter-phase enum.
package i2c_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_ACK1  = 3'd2,
    ST_ADDR  = 3'd3,
    ST_STOP  = 3'd5,
    ST_DATA  = 3'd6,
    ST_ACK2  = 3'd7
  } state_e;

  typedef enum logic [1:0] {Q0, Q1, Q2, Q3} qphase_e;
endpackage

// File: rtl/i2c_master_controlpath_if.sv
// Request/response and open-drain bus signals of the I2C master control path.
interface i2c_master_if;
  import i2c_pkg::*;
  logic              start_req;
  logic              rw_req;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              sda_in;
  logic              scl_in;
  logic              scl_oe;
  logic              sda_oe;
  logic [DATA_W-1:0] rdata;
  logic              busy;
  logic              done;
  logic              error_master;
  state_e            state;

  modport master (
    input  start_req, rw_req, addr, wdata, sda_in, scl_in,
    output scl_oe, sda_oe, rdata, busy, done, error_master, state
  );
  modport slave (
    output start_req, rw_req, addr, wdata, sda_in, scl_in,
    input  scl_oe, sda_oe, rdata, busy, done, error_master, state
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// SCL quarter-phase divider: tick every CLK_DIV cycles, phase Q0..Q3 per bit.
// With I2C_CLK_STRETCH_EN defined, Q1 is held while a slave keeps SCL low.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic    clk1,
  input  logic    rst,
  input  logic    en,
`ifdef I2C_CLK_STRETCH_EN
  input  logic    scl_in,
`endif
  output logic    tick,
  output qphase_e phase
);
  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);

  logic [QW-1:0] qcnt;
  logic          hold;

`ifdef I2C_CLK_STRETCH_EN
  // SCL was released at Q1; a low line means the slave is stretching
  assign hold = (phase == Q1) && !scl_in;
`else
  assign hold = 1'b0;
`endif

  assign tick = en && !hold && (qcnt == QMAX);

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      qcnt  <= '0;
      phase <= Q0;
    end else if (!en) begin
      qcnt  <= '0;
      phase <= Q0;
    end else if (!hold) begin
      if (qcnt == QMAX) begin
        qcnt  <= '0;
        phase <= qphase_e'(phase + 2'd1);
      end else begin
        qcnt <= qcnt + QW'(1);
      end
    end
  end
endmodule

// File: rtl/i2c_master_controlpath.sv
// Single-byte I2C master: START, {addr,rw}, ACK check, one data byte, ACK/NACK, STOP.
// Optional I2C_CLK_STRETCH_EN lets a slave stretch SCL during Q1.
module i2c_master_controlpath
  import i2c_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic          clk1,
  input  logic          rst,
  i2c_master_if.master  bus
);
  state_e            state_q, state_n;
  qphase_e           phase, phase_n;
  logic              tick, bit_end, q2_tick;
  logic [2:0]        bit_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              rw_q;
  logic [DATA_W-1:0] wdata_q, rd_sh, rdata_q;
  logic              sda_smp, busy_q, done_q, err_q, scl_oe_q, sda_oe_q;

  i2c_scl_gen #(.CLK_DIV(CLK_DIV)) u_scl_gen (
    .clk1  (clk1),
    .rst   (rst),
    .en    (state_q != ST_IDLE),
`ifdef I2C_CLK_STRETCH_EN
    .scl_in(bus.scl_in),
`endif
    .tick  (tick),
    .phase (phase)
  );

  assign bit_end = tick && (phase == Q3);
  assign q2_tick = tick && (phase == Q2);
  assign phase_n = tick ? qphase_e'(phase + 2'd1) : phase;

  function automatic logic scl_low(state_e st, qphase_e ph);
    case (st)
      ST_IDLE, ST_START: return 1'b0;
      default:           return ph == Q0;
    endcase
  endfunction

  function automatic logic sda_low(state_e st, qphase_e ph, logic [2:0] idx,
                                   logic [DATA_W-1:0] abyte, logic [DATA_W-1:0] wbyte,
                                   logic rd);
    case (st)
      ST_START: return (ph == Q2) || (ph == Q3);
      ST_ADDR:  return !abyte[idx];
      ST_DATA:  return !rd && !wbyte[idx];
      ST_STOP:  return (ph == Q0) || (ph == Q1);
      default:  return 1'b0;
    endcase
  endfunction

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE:  if (bus.start_req) state_n = ST_START;
      ST_START: if (bit_end) state_n = ST_ADDR;
      ST_ADDR:  if (bit_end && bit_cnt == 3'd0) state_n = ST_ACK1;
      ST_ACK1:  if (bit_end) state_n = sda_smp ? ST_STOP : ST_DATA;
      ST_DATA:  if (bit_end && bit_cnt == 3'd0) state_n = ST_ACK2;
      ST_ACK2:  if (bit_end) state_n = ST_STOP;
      ST_STOP:  if (bit_end) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // SCL follows the next phase; SDA follows one cycle later so it always moves behind SCL falling
  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      bit_cnt  <= 3'd7;
      sda_smp  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      scl_oe_q <= 1'b0;
      sda_oe_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_n;
      done_q   <= 1'b0;
      scl_oe_q <= scl_low(state_n, phase_n);
      sda_oe_q <= sda_low(state_q, phase, bit_cnt, {addr_q, rw_q}, wdata_q, rw_q);
      if (state_n != state_q)
        bit_cnt <= 3'd7;
      else if (bit_end)
        bit_cnt <= bit_cnt - 3'd1;
      if (q2_tick)
        sda_smp <= bus.sda_in;
      if (state_q == ST_IDLE && bus.start_req) begin
        busy_q <= 1'b1;
        err_q  <= 1'b0;
      end
      if (bit_end && sda_smp && (state_q == ST_ACK1 || (state_q == ST_ACK2 && !rw_q)))
        err_q <= 1'b1;
      if (state_q == ST_STOP && bit_end) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
        if (rw_q && !err_q)
          rdata_q <= rd_sh;
      end
    end
  end

  always_ff @(posedge clk1) begin
    if (state_q == ST_IDLE && bus.start_req) begin
      addr_q  <= bus.addr;
      rw_q    <= bus.rw_req;
      wdata_q <= bus.wdata;
    end
    if (state_q == ST_DATA && q2_tick)
      rd_sh <= {rd_sh[DATA_W-2:0], bus.sda_in};
  end

  assign bus.scl_oe       = scl_oe_q;
  assign bus.sda_oe       = sda_oe_q;
  assign bus.rdata        = rdata_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.error_master = err_q;
  assign bus.state        = state_q;
endmodule
